// File: rtl/fp_to_linear.sv
// Decoder from sign/exponent/mantissa floating point to a two's-complement linear value.
// Define FPDEC_FASTPATH_EN for a single-cycle barrel-shifter decode; otherwise one shift step per cycle.
module fp_to_linear #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5,
  parameter int OUT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [MAN_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D,
  output logic             busy
);

  // The largest mantissa shifted by the largest exponent, plus a sign bit, must fit in OUT_W.
  generate
    if (OUT_W < MAN_W + (1 << EXP_W)) begin : g_width_check
      $fatal(1, "fp_to_linear: OUT_W too small for MAN_W and EXP_W");
    end
  endgenerate

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

`ifdef FPDEC_FASTPATH_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [EXP_W-1:0] CNT_ONE = EXP_W'(1);
`endif

  function automatic logic [OUT_W-1:0] apply_sign(input logic neg,
                                                  input logic [OUT_W-1:0] m);
    return neg ? (~m + ONE) : m;
  endfunction

  state_t           state, state_nx;
  logic             in_ready_nx;
  logic             out_valid_nx;
  logic [OUT_W-1:0] d_nx;
  logic [OUT_W-1:0] f_ext;

  assign f_ext = {{(OUT_W-MAN_W){1'b0}}, F};
  assign busy  = (state != IDLE);

`ifdef FPDEC_FASTPATH_EN

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      D         <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      D         <= d_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    d_nx         = D;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          d_nx         = apply_sign(S, f_ext << E);
          out_valid_nx = 1'b1;
          in_ready_nx  = 1'b0;
          state_nx     = DONE;
        end else begin
          in_ready_nx = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`else

  logic [OUT_W-1:0] mag, mag_nx;
  logic [EXP_W-1:0] cnt, cnt_nx;
  logic             sgn, sgn_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      D         <= '0;
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      D         <= d_nx;
      mag       <= mag_nx;
      cnt       <= cnt_nx;
      sgn       <= sgn_nx;
    end
  end

  // Magnitude is shifted one bit per cycle; the sign is applied once at the end.
  always_comb begin
    state_nx     = state;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    d_nx         = D;
    mag_nx       = mag;
    cnt_nx       = cnt;
    sgn_nx       = sgn;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mag_nx      = f_ext;
          cnt_nx      = E;
          sgn_nx      = S;
          in_ready_nx = 1'b0;
          state_nx    = SHIFT;
        end else begin
          in_ready_nx = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          mag_nx = mag << 1;
          cnt_nx = cnt - CNT_ONE;
        end else begin
          state_nx = SIGN;
        end
      end
      SIGN: begin
        d_nx         = apply_sign(sgn, mag);
        out_valid_nx = 1'b1;
        state_nx     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`endif

endmodule

// File: tb/tb_fp_to_linear.sv
// Scoreboard bench for fp_to_linear: decoded values, latency, handshake, backpressure and reset.
module tb_fp_to_linear;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [4:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] D;
  logic        busy;

  fp_to_linear #(.EXP_W(3), .MAN_W(5), .OUT_W(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F),
    .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .busy(busy)
  );

  typedef struct {
    logic [12:0] d;
    int          lat;
    int          acc;
  } sb_t;

  sb_t sb[$];
  sb_t ent;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  logic ov_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] model(input logic s, input logic [2:0] e, input logic [4:0] f);
    int v;
    v = int'(f) << e;
    if (s) v = -v;
    return v[12:0];
  endfunction

  // Edges from the accept edge to the edge that raises out_valid.
  function automatic int lat_of(input logic [2:0] e);
`ifdef FPDEC_FASTPATH_EN
    return 0;
`else
    return int'(e) + 2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [2:0] e, input logic [4:0] f);
    int n;
    sb_t it;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    S = s;
    E = e;
    F = f;
    tick();
    it.d   = model(s, e, f);
    it.lat = lat_of(e);
    it.acc = cyc;
    sb.push_back(it);
    in_valid = 1'b0;
    S = 1'($urandom);
    E = 3'($urandom);
    F = 5'($urandom);
  endtask

  task automatic wait_out(input int max);
    int n;
    n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    chk("wait_ov", out_valid, 1);
  endtask

  task automatic run(input logic s, input logic [2:0] e, input logic [4:0] f,
                     input logic [12:0] dexp);
    int n;
    send(s, e, f);
    n = 0;
    while (!out_valid && n < 20) begin
      chk("busy", busy, 1);
      tick();
      n++;
    end
    chk("wait_ov", out_valid, 1);
    chk("busy_done", busy, 1);
    chk("D_plan", D, dexp);
    chk("ir_low", in_ready, 0);
    tick();
    chk("ov_drop", out_valid, 0);
    chk("ir_back", in_ready, 1);
  endtask

  // Pops on the output handshake; an unexpected rise of out_valid finds the queue empty.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        ent = sb.pop_front();
        chk("D", D, ent.d);
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rs;
    logic [2:0]  re;
    logic [4:0]  rf;
    int          n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    S = 1'b0;
    E = '0;
    F = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_D", D, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("ir_before_edge", in_ready, 0);
    tick();
    chk("ir_rise", in_ready, 1);

    run(1'b0, 3'd0, 5'd5, 13'h0005);
    run(1'b0, 3'd3, 5'd22, 13'h00B0);
    run(1'b1, 3'd7, 5'd31, 13'h1080);
    run(1'b1, 3'd2, 5'd0, 13'h0000);

    out_ready = 1'b0;
    send(1'b1, 3'd1, 5'd3);
    wait_out(20);
    for (int i = 0; i < 4; i++) begin
      chk("bp_D", D, 13'h1FFA);
      chk("bp_ov", out_valid, 1);
      chk("bp_ir", in_ready, 0);
      in_valid = 1'b1;
      S = 1'b0;
      E = 3'd2;
      F = 5'd9;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_ir_back", in_ready, 1);
    repeat (12) tick();

    send(1'b0, 3'd6, 5'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ir", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run(1'b0, 3'd1, 5'd1, 13'h0002);
    repeat (15) tick();

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom);
      re = 3'($urandom);
      rf = 5'($urandom);
      run(rs, re, rf, model(rs, re, rf));
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
